// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - shares one pipelined main memory between I-cache and D-cache miss handlers
module cache_mem_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int BLOCK_WORDS = 8,
  parameter int MEM_LAT     = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_req,
  input  logic [ADDR_W-1:0]              i_addr,
  input  logic                           d_req,
  input  logic                           d_we,
  input  logic [ADDR_W-1:0]              d_addr,
  input  logic [DATA_W-1:0]              d_wdata,
  output logic                           mem_en,
  output logic                           mem_wr,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [DATA_W-1:0]              mem_wdata,
  input  logic [DATA_W-1:0]              mem_rdata,
  input  logic                           mem_rvalid,
  output logic [DATA_W-1:0]              fill_data,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_idx,
  output logic                           i_fill_valid,
  output logic                           d_fill_valid,
  output logic                           i_done,
  output logic                           d_done,
  output logic                           busy
);

  localparam int IDX_W = $clog2(BLOCK_WORDS);
  localparam int OFF_W = IDX_W + 1;
  localparam int CNT_W = IDX_W + 1;
  localparam int DRN_W = $clog2(MEM_LAT + 1);

  typedef enum logic [2:0] {
    DRAIN   = 3'd0,
    IDLE    = 3'd1,
    I_FILL  = 3'd2,
    D_FILL  = 3'd3,
    D_WRITE = 3'd4
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    issue_cnt;
  logic [CNT_W-1:0]    recv_cnt;
  logic [DRN_W-1:0]    drain_cnt;
  logic                last_i;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;

  logic filling;
  logic issuing;
  logic rx;
  logic last_rx;
  logic grant_i;

  assign filling = (state == I_FILL) || (state == D_FILL);
  assign issuing = rst_n && filling && (issue_cnt < CNT_W'(BLOCK_WORDS));
  assign rx      = rst_n && filling && mem_rvalid;
  assign last_rx = rx && (recv_cnt == CNT_W'(BLOCK_WORDS - 1));
  // I wins when alone, or on contention when D was served last
  assign grant_i = i_req && (!d_req || !last_i);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= DRAIN;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      drain_cnt <= '0;
      last_i    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      case (state)
        // reads launched before a reset may still come back; let them die here
        DRAIN: begin
          if (drain_cnt == DRN_W'(MEM_LAT - 1)) begin
            state     <= IDLE;
            drain_cnt <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        IDLE: begin
          issue_cnt <= '0;
          recv_cnt  <= '0;
          if (grant_i) begin
            state  <= I_FILL;
            last_i <= 1'b1;
            addr_q <= {i_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          end else if (d_req) begin
            last_i  <= 1'b0;
            wdata_q <= d_wdata;
            if (d_we) begin
              state  <= D_WRITE;
              addr_q <= d_addr;
            end else begin
              state  <= D_FILL;
              addr_q <= {d_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            end
          end
        end
        I_FILL, D_FILL: begin
          if (issuing) issue_cnt <= issue_cnt + 1'b1;
          if (rx)      recv_cnt  <= recv_cnt + 1'b1;
          if (last_rx) begin
            state     <= IDLE;
            issue_cnt <= '0;
            recv_cnt  <= '0;
          end
        end
        D_WRITE: state <= IDLE;
        default: state <= DRAIN;
      endcase
    end
  end

  // every output is forced low while reset is held, independent of state
  always_comb begin
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    fill_data    = '0;
    fill_idx     = '0;
    i_fill_valid = 1'b0;
    d_fill_valid = 1'b0;
    i_done       = 1'b0;
    d_done       = 1'b0;
    busy         = 1'b0;
    if (rst_n) begin
      busy      = (state != IDLE);
      fill_data = mem_rdata;
      fill_idx  = recv_cnt[IDX_W-1:0];
      if (issuing) begin
        mem_en   = 1'b1;
        mem_addr = {addr_q[ADDR_W-1:OFF_W], issue_cnt[IDX_W-1:0], 1'b0};
      end
      if (state == D_WRITE) begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        d_done    = 1'b1;
      end
      i_fill_valid = rx && (state == I_FILL);
      d_fill_valid = rx && (state == D_FILL);
      i_done       = last_rx && (state == I_FILL);
      if (last_rx && (state == D_FILL)) d_done = 1'b1;
    end
  end

endmodule
